// File: rtl/sccb_master.sv
`timescale 1ns/1ps
// sccb_master
//   Bit-level SCCB/IIC master for the camera configuration sequencer.
//   Executes one register write (START 42 addr data STOP) or register read
//   (START 42 addr STOP, START 43 [data] NACK STOP) per level-held command.
//   Each bit is split into four quarters of QDIV clocks:
//   q0 SCL low/SDA change, q1 SCL high, q2 SCL high/SDA sample, q3 SCL low.
//
// Ports
//   clk_100M     system clock
//   rst_p        asynchronous active-high reset (releases the bus at once)
//   iic_cmd      2'b10 write, 2'b01 read, otherwise no-op (level-held)
//   reg_addr     sensor register address, latched at the end of START
//   wr_data      write data, latched at the end of START
//   rd_data      last byte read, updated at the DONE of a read
//   device_done  power-up delay elapsed (sticky until reset)
//   iic_ack      1 = at least one NACK seen in the last transaction
//   write_done   one-cycle pulse ending a write
//   read_done    one-cycle pulse ending a read
//   busy         high from leaving IDLE through the DONE cycle
//   scl          SCL, push-pull (single master)
//   sda_t        1 = release SDA, 0 = drive SDA low
//   sda_i        SDA pad input (raw, synchronized here)
module sccb_master #(
  parameter int          CLK_FREQ     = 100_000_000,
  parameter int          IIC_FREQ     = 100_000,
  parameter logic [6:0]  DEV_ADDR     = 7'h21,
  parameter int          PWRUP_CYCLES = 100_000
) (
  input  logic       clk_100M,
  input  logic       rst_p,
  input  logic [1:0] iic_cmd,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       device_done,
  output logic       iic_ack,
  output logic       write_done,
  output logic       read_done,
  output logic       busy,
  output logic       scl,
  output logic       sda_t,
  input  logic       sda_i
);

  localparam int          QDIV  = CLK_FREQ / (4 * IIC_FREQ);
  localparam logic [15:0] QLAST = 16'(QDIV - 1);
  localparam int          PW_W  = $clog2(PWRUP_CYCLES + 1);
  localparam logic [PW_W-1:0] PW_LAST = PW_W'(PWRUP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_PWRUP = 3'd0,
    S_IDLE  = 3'd1,
    S_START = 3'd2,
    S_BYTE  = 3'd3,
    S_STOP  = 3'd4,
    S_BUF   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t          state;
  logic [PW_W-1:0] pw_cnt;
  logic [15:0]     qcnt;
  logic [1:0]      quarter;
  logic [3:0]      bit_cnt;     // 0..7 data bits, 8 = ACK slot
  logic [1:0]      byte_idx;    // byte within the current START..STOP frame
  logic            phase;       // read only: 0 = address frame, 1 = data frame
  logic            op_rd;
  logic [7:0]      addr_q;
  logic [7:0]      data_q;
  logic [7:0]      rx_sh;
  logic            ack_acc;
  logic [1:0]      sda_sync;

  logic qtick, sda_s, last_byte, rx_byte;

  assign qtick     = (qcnt == QLAST);
  assign sda_s     = sda_sync[1];
  // Frame layout: write = 3 bytes, each read frame = 2 bytes.
  assign last_byte = op_rd ? (byte_idx == 2'd1) : (byte_idx == 2'd2);
  // Second byte of the read data frame is driven by the sensor.
  assign rx_byte   = phase && (byte_idx == 2'd1);

  // SDA level to present in q0 of bit bc of byte bi. The ACK slot and every
  // bit of the received byte are released; in the read byte's 9th bit this
  // release is the master NACK.
  function automatic logic bit_val(input logic [1:0] bi, input logic [3:0] bc,
                                   input logic ph, input logic [7:0] a,
                                   input logic [7:0] d);
    logic [7:0] b;
    case (bi)
      2'd0:    b = {DEV_ADDR, ph};
      2'd1:    b = a;
      default: b = d;
    endcase
    if (bc == 4'd8 || (ph && bi == 2'd1)) return 1'b1;
    return b[~bc[2:0]];
  endfunction

  always_ff @(posedge clk_100M or posedge rst_p) begin
    if (rst_p) sda_sync <= 2'b11;
    else       sda_sync <= {sda_sync[0], sda_i};
  end

  // Outputs for quarter k+1 are registered at the tick that ends quarter k,
  // so scl/sda_t only move on quarter boundaries.
  always_ff @(posedge clk_100M or posedge rst_p) begin
    if (rst_p) begin
      state       <= S_PWRUP;
      pw_cnt      <= '0;
      qcnt        <= '0;
      quarter     <= '0;
      bit_cnt     <= '0;
      byte_idx    <= '0;
      phase       <= 1'b0;
      op_rd       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rx_sh       <= '0;
      ack_acc     <= 1'b0;
      rd_data     <= '0;
      device_done <= 1'b0;
      iic_ack     <= 1'b0;
      write_done  <= 1'b0;
      read_done   <= 1'b0;
      busy        <= 1'b0;
      scl         <= 1'b1;
      sda_t       <= 1'b1;
    end else begin
      write_done <= 1'b0;
      read_done  <= 1'b0;
      qcnt       <= qtick ? 16'd0 : qcnt + 16'd1;
      if (qtick) quarter <= quarter + 2'd1;

      case (state)
        S_PWRUP: begin
          qcnt    <= '0;
          quarter <= '0;
          if (pw_cnt == PW_LAST) begin
            device_done <= 1'b1;
            state       <= S_IDLE;
          end else begin
            pw_cnt <= pw_cnt + 1'b1;
          end
        end

        S_IDLE: begin
          qcnt     <= '0;
          quarter  <= '0;
          bit_cnt  <= '0;
          byte_idx <= '0;
          phase    <= 1'b0;
          scl      <= 1'b1;
          sda_t    <= 1'b1;
          if (iic_cmd == 2'b10 || iic_cmd == 2'b01) begin
            op_rd <= (iic_cmd == 2'b01);
            busy  <= 1'b1;
            state <= S_START;
          end
        end

        S_START: if (qtick) begin
          case (quarter)
            2'd1: sda_t <= 1'b0;
            2'd2: scl   <= 1'b0;
            2'd3: begin
              state    <= S_BYTE;
              bit_cnt  <= '0;
              byte_idx <= '0;
              sda_t    <= bit_val(2'd0, 4'd0, phase, addr_q, data_q);
              // Operands only matter for the first frame; the read data
              // frame reuses nothing, so the sequencer may already move on.
              if (!phase) begin
                addr_q <= reg_addr;
                data_q <= wr_data;
              end
            end
            default: ;
          endcase
        end

        S_BYTE: if (qtick) begin
          case (quarter)
            2'd0: scl <= 1'b1;
            2'd2: begin
              scl <= 1'b0;
              if (bit_cnt == 4'd8) begin
                if (!rx_byte) ack_acc <= ack_acc | sda_s;
              end else if (rx_byte) begin
                rx_sh <= {rx_sh[6:0], sda_s};
              end
            end
            2'd3: begin
              if (bit_cnt == 4'd8) begin
                bit_cnt <= '0;
                if (last_byte) begin
                  state <= S_STOP;
                  sda_t <= 1'b0;
                end else begin
                  byte_idx <= byte_idx + 2'd1;
                  sda_t    <= bit_val(byte_idx + 2'd1, 4'd0, phase, addr_q, data_q);
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
                sda_t   <= bit_val(byte_idx, bit_cnt + 4'd1, phase, addr_q, data_q);
              end
            end
            default: ;
          endcase
        end

        S_STOP: if (qtick) begin
          case (quarter)
            2'd0: scl   <= 1'b1;
            2'd2: sda_t <= 1'b1;
            2'd3: state <= S_BUF;
            default: ;
          endcase
        end

        S_BUF: if (qtick && quarter == 2'd3) begin
          if (op_rd && !phase) begin
            phase <= 1'b1;
            state <= S_START;
          end else begin
            state   <= S_DONE;
            iic_ack <= ack_acc;
            ack_acc <= 1'b0;
            if (op_rd) begin
              read_done <= 1'b1;
              rd_data   <= rx_sh;
            end else begin
              write_done <= 1'b1;
            end
          end
        end

        S_DONE: begin
          qcnt    <= '0;
          quarter <= '0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end

        default: begin
          qcnt    <= '0;
          quarter <= '0;
          busy    <= 1'b0;
          scl     <= 1'b1;
          sda_t   <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_master.sv
`timescale 1ns/1ps
// tb_sccb_master
//   Directed bench for sccb_master with QDIV = 4 and a 1000-clock power-up.
//   A behavioural SCCB slave decodes the bus into an event log (START = -1,
//   STOP = -2, bytes 0..255) and an ACK-bit log, ACKs or NACKs on request,
//   and returns rd_val on reads.
module tb_sccb_master;
  localparam int QDIV = 4;

  logic       clk_100M = 1'b0;
  logic       rst_p    = 1'b1;
  logic [1:0] iic_cmd  = 2'b00;
  logic [7:0] reg_addr = 8'h00;
  logic [7:0] wr_data  = 8'h00;
  logic [7:0] rd_data;
  logic       device_done, iic_ack, write_done, read_done, busy, scl, sda_t;
  logic       slv_sda = 1'b1;
  logic       bus_sda;

  assign bus_sda = sda_t & slv_sda;

  sccb_master #(
    .CLK_FREQ(1_600_000), .IIC_FREQ(100_000), .DEV_ADDR(7'h21), .PWRUP_CYCLES(1000)
  ) dut (
    .clk_100M(clk_100M), .rst_p(rst_p), .iic_cmd(iic_cmd), .reg_addr(reg_addr),
    .wr_data(wr_data), .rd_data(rd_data), .device_done(device_done), .iic_ack(iic_ack),
    .write_done(write_done), .read_done(read_done), .busy(busy), .scl(scl),
    .sda_t(sda_t), .sda_i(bus_sda)
  );

  always #5 clk_100M = ~clk_100M;

  int cyc_now = 0;
  always @(posedge clk_100M) cyc_now <= cyc_now + 1;

  // ---------------- slave / bus monitor ----------------
  int         ev[$];
  logic       acks[$];
  int         nack_byte = -1;
  logic [7:0] rd_val = 8'h76;
  int         bitn = 0, byte_no = 0, stop_cyc = 0, last_gap = 0, scl_falls = 0;
  logic [7:0] sh = 8'h00;
  bit         in_xfer = 0, seen_rise = 0, rd_dir = 0, have_stop = 0;
  logic       p_scl = 1'b1, p_sda = 1'b1;

  always @(scl or bus_sda or rst_p) begin
    if (rst_p) begin
      in_xfer   = 0;
      seen_rise = 0;
      bitn      = 0;
      slv_sda  <= 1'b1;
    end else if (scl === 1'b1 && p_scl === 1'b1 && bus_sda !== p_sda) begin
      if (bus_sda === 1'b0) begin
        ev.push_back(-1);
        if (have_stop) last_gap = cyc_now - stop_cyc;
        in_xfer = 1; seen_rise = 0; bitn = 0; byte_no = 0; rd_dir = 0;
      end else if (in_xfer) begin
        ev.push_back(-2);
        in_xfer = 0; have_stop = 1; stop_cyc = cyc_now;
      end
    end else if (scl !== p_scl) begin
      if (scl === 1'b1) begin
        seen_rise = 1;
        if (in_xfer) begin
          if (bitn < 8) sh = {sh[6:0], bus_sda};
          else          acks.push_back(bus_sda);
        end
      end else begin
        scl_falls++;
        if (in_xfer && seen_rise) begin
          seen_rise = 0;
          if (bitn == 7) begin
            ev.push_back(int'(sh));
            if (byte_no == 0) rd_dir = sh[0];
            bitn = 8;
            slv_sda <= (rd_dir && byte_no >= 1) ? 1'b1 : (byte_no == nack_byte);
          end else if (bitn == 8) begin
            byte_no++;
            bitn = 0;
            slv_sda <= (rd_dir && byte_no == 1) ? rd_val[7] : 1'b1;
          end else begin
            bitn++;
            slv_sda <= (rd_dir && byte_no == 1) ? rd_val[3'(7 - bitn)] : 1'b1;
          end
        end
      end
    end
    p_scl = scl;
    p_sda = bus_sda;
  end

  // ---------------- checking helpers ----------------
  int   errors = 0, checks = 0;
  int   n, base, abase;
  int   exp_ev[$];
  logic exp_ack[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_log(input string tag, input int b);
    chk({tag, "_len"}, ev.size() - b, exp_ev.size());
    for (int i = 0; i < exp_ev.size() && b + i < ev.size(); i++)
      chk($sformatf("%s_%0d", tag, i), ev[b + i], exp_ev[i]);
  endtask

  task automatic chk_acks(input string tag, input int b);
    chk({tag, "_len"}, acks.size() - b, exp_ack.size());
    for (int i = 0; i < exp_ack.size() && b + i < acks.size(); i++)
      chk($sformatf("%s_%0d", tag, i), acks[b + i], exp_ack[i]);
  endtask

  // Bounded wait for the done pulse; n = negedges counted.
  task automatic wait_done(input bit rd, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk_100M);
      cnt++;
    end while (!(rd ? read_done : write_done) && cnt < 5000);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    iic_cmd = 2'b10; reg_addr = 8'h12; wr_data = 8'h80;
    repeat (3) @(negedge clk_100M);
    chk("rst_scl", scl, 1);
    chk("rst_sda_t", sda_t, 1);
    chk("rst_device_done", device_done, 0);
    chk("rst_write_done", write_done, 0);
    chk("rst_read_done", read_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_iic_ack", iic_ack, 0);
    chk("rst_rd_data", rd_data, 8'h00);

    // Power-up with a write command already held.
    rst_p = 1'b0;
    repeat (999) @(negedge clk_100M);
    chk("pwrup_early", device_done, 0);
    @(negedge clk_100M);
    chk("pwrup_done", device_done, 1);
    chk("pwrup_no_scl", scl_falls, 0);
    chk("pwrup_idle_busy", busy, 0);

    // Write 12 <- 80, all ACKed.
    base = ev.size(); abase = acks.size();
    wait_done(0, n);
    iic_cmd = 2'b00;
    chk("wr_latency", n, 481);
    chk("wr_busy_in_done", busy, 1);
    chk("wr_iic_ack", iic_ack, 0);
    @(negedge clk_100M);
    chk("wr_single_pulse", write_done, 0);
    chk("wr_busy_after", busy, 0);
    exp_ev = '{-1, 'h42, 'h12, 'h80, -2};
    chk_log("wr_bus", base);
    exp_ack = '{1'b0, 1'b0, 1'b0};
    chk_acks("wr_acks", abase);

    // Data byte NACKed: still completes with STOP, iic_ack = 1.
    base = ev.size(); abase = acks.size();
    nack_byte = 2; reg_addr = 8'h34; wr_data = 8'h56; iic_cmd = 2'b10;
    wait_done(0, n);
    iic_cmd = 2'b00;
    chk("nack_latency", n, 481);
    chk("nack_iic_ack", iic_ack, 1);
    exp_ev = '{-1, 'h42, 'h34, 'h56, -2};
    chk_log("nack_bus", base);
    exp_ack = '{1'b0, 1'b0, 1'b1};
    chk_acks("nack_acks", abase);
    @(negedge clk_100M);
    chk("nack_ack_holds", iic_ack, 1);
    nack_byte = -1; reg_addr = 8'h35; iic_cmd = 2'b10;
    wait_done(0, n);
    iic_cmd = 2'b00;
    chk("ack_cleared", iic_ack, 0);

    // Read 0A, slave returns 76.
    @(negedge clk_100M);
    base = ev.size(); abase = acks.size();
    reg_addr = 8'h0A; iic_cmd = 2'b01;
    wait_done(1, n);
    iic_cmd = 2'b00;
    chk("rd_latency", n, 673);
    chk("rd_data", rd_data, 8'h76);
    chk("rd_iic_ack", iic_ack, 0);
    exp_ev = '{-1, 'h42, 'h0A, -2, -1, 'h43, 'h76, -2};
    chk_log("rd_bus", base);
    exp_ack = '{1'b0, 1'b0, 1'b0, 1'b1};
    chk_acks("rd_acks", abase);

    // Back-to-back writes; the stub advances reg_addr on write_done.
    @(negedge clk_100M);
    base = ev.size();
    reg_addr = 8'h20; wr_data = 8'h11; iic_cmd = 2'b10;
    wait_done(0, n);
    reg_addr = 8'h21;
    wait_done(0, n);
    iic_cmd = 2'b00;
    chk("b2b_latency", n, 482);
    exp_ev = '{-1, 'h42, 'h20, 'h11, -2, -1, 'h42, 'h21, 'h11, -2};
    chk_log("b2b_bus", base);
    chk("b2b_bus_free", (last_gap >= 4 * QDIV), 1);
    chk("rd_data_holds", rd_data, 8'h76);

    // Reset in bit 5 of the address byte (q0: SCL low, SDA low).
    @(negedge clk_100M);
    reg_addr = 8'h55; wr_data = 8'h66; iic_cmd = 2'b10;
    repeat (100) @(negedge clk_100M);
    chk("mid_busy_pre", busy, 1);
    chk("mid_scl_pre", scl, 0);
    chk("mid_sda_pre", sda_t, 0);
    rst_p = 1'b1;
    #1;
    chk("mid_scl", scl, 1);
    chk("mid_sda_t", sda_t, 1);
    chk("mid_busy", busy, 0);
    chk("mid_device_done", device_done, 0);
    @(negedge clk_100M);
    rst_p = 1'b0;
    base = ev.size();
    repeat (1000) @(negedge clk_100M);
    chk("mid_pwrup", device_done, 1);
    wait_done(0, n);
    iic_cmd = 2'b00;
    chk("mid_wr_latency", n, 481);
    exp_ev = '{-1, 'h42, 'h55, 'h66, -2};
    chk_log("mid_bus", base);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
